dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single core data-memory port (valid/ready, byte-lane write enables) between N_MASTERS requesters: the LSU on master 0, plus other data masters such as a debug or DMA engine. It sits between the requesters and the data memory. It grants in the same cycle a request appears and locks the grant until the memory accepts the transaction. It then re-arbitrates by fixed priority or by round-robin, selected at compile time.

## Interface
- N_MASTERS, 2, number of requesters (2..8); index 0 is the LSU.
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- m_valid_i  input  [N_MASTERS]  per-master request; held until that master's m_ready_o.
- m_addr_i  input  [N_MASTERS][RISCV_ADDR_WIDTH]  per-master byte address.
- m_wdata_i  input  [N_MASTERS][RISCV_WORD_WIDTH]  per-master lane-placed write data.
- m_we_i  input  [N_MASTERS][4]  per-master byte write enables; 4'h0 means read.
- m_ready_o  output  [N_MASTERS]  one-hot completion to the owner only.
- m_rdata_o  output  RISCV_WORD_WIDTH  memory read data, broadcast to all masters.
- dmem_valid_o  output  1  request to memory.
- dmem_ready_i  input  1  memory completion; read data valid in the same cycle.
- dmem_addr_o  output  RISCV_ADDR_WIDTH  granted master's address.
- dmem_wdata_o  output  RISCV_WORD_WIDTH  granted master's write data.
- dmem_we_o  output  4  granted master's enables; forced 4'h0 when dmem_valid_o is 0.
- dmem_rdata_i  input  RISCV_WORD_WIDTH  memory read data.
- grant_o  output  [N_MASTERS]  one-hot current grant; 0 when no request.
- busy_o  output  1  arbiter is in ARB_BUSY.
- protocol_err_o  output  1  one-cycle pulse when the owner drops valid while locked.

## Operation
- State machine: ARB_IDLE and ARB_BUSY. Registers: state, owner index, rr_ptr.
- In ARB_IDLE, the winner is chosen combinationally from m_valid_i (see Configuration). In ARB_BUSY, the winner is the registered owner.
- Outputs derived from the winner:
  - dmem_valid_o = m_valid_i[winner].
  - dmem_addr_o, dmem_wdata_o and dmem_we_o are muxed from the winner.
  - m_ready_o[winner] = dmem_ready_i & dmem_valid_o; all other m_ready_o bits are 0.
- ARB_IDLE -> ARB_BUSY when dmem_valid_o & !dmem_ready_i; the winner is latched as owner.
- ARB_IDLE stays in ARB_IDLE when a transaction completes in one cycle.
- ARB_BUSY -> ARB_IDLE when dmem_ready_i & dmem_valid_o (completion).
- ARB_BUSY -> ARB_IDLE when m_valid_i[owner] == 0. This is a protocol violation: protocol_err_o pulses in that cycle and dmem_valid_o is 0 in that cycle.
- On every completion, rr_ptr <= (winner + 1) mod N_MASTERS. Without the macro the pointer is still maintained but unused.
- Non-owner requests are ignored while in ARB_BUSY; they wait with m_ready_o = 0.
- m_rdata_o = dmem_rdata_i, unregistered.

## Timing
- Reset values:
  - state = ARB_IDLE, owner = 0, rr_ptr = 0.
  - While rst_n == 0, dmem_valid_o, m_ready_o, grant_o, busy_o and protocol_err_o are all 0, and dmem_we_o = 4'h0.
- Zero-cycle arbitration: a request in cycle t drives dmem_valid_o in cycle t.
- Minimum transaction is 1 cycle. Back-to-back completions are possible every cycle.
- Re-arbitration happens in the cycle after a completion, using the updated rr_ptr.
- A request arriving in the same cycle that another master completes is served no earlier than the next cycle.
- Reset asserted mid-transaction drops the lock immediately. The memory must tolerate an aborted request.
- dmem_we_o and dmem_addr_o are stable for the whole locked transaction, provided the owner holds its inputs stable.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at rr_ptr and wraps modulo N_MASTERS; the first requester found wins.
  - This gives starvation-free service: each waiting master is served within N_MASTERS-1 other transactions.
- DMEM_ARB_RR_EN undefined: fixed priority; the lowest index wins, so the LSU always wins ties.

## Structure
- Package dmem_arb_pkg:
  - typedef enum logic arb_state_e {ARB_IDLE, ARB_BUSY}.
  - localparam DMEM_ARB_MAX_MASTERS = 8.
  - Function for a one-hot to index conversion.
  - RISCV_ADDR_WIDTH and RISCV_WORD_WIDTH come from riscv_defines.sv.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Implements both the rotate-and-priority-encode (round-robin) and the plain priority-encode (fixed) selection.

## Test plan
- Single master 0 read, memory ready the same cycle: m_valid_i=2'b01, addr=0x100, dmem_ready_i=1 -> dmem_valid_o=1, dmem_addr_o=0x100, m_ready_o=2'b01, busy_o stays 0.
- Locked grant: master 1 requests at t0 with ready=0 for 3 cycles; master 0 requests at t1 -> dmem_addr_o stays on master 1 through t3; m_ready_o=2'b10 at t3; master 0 is granted at t4.
- Round-robin (DMEM_ARB_RR_EN): both masters request continuously with ready=1 -> grant_o alternates 01,10,01,10. Without the macro, grant_o stays 01.
- Protocol violation: master 0 locked with ready=0, then m_valid_i[0] drops -> protocol_err_o=1 for one cycle, dmem_valid_o=0, busy_o=0 the next cycle.
- Reset mid-transaction: rst_n low during ARB_BUSY -> all outputs go to 0 immediately; after release, state=ARB_IDLE and a master 1-only request is granted at once.
- Write forwarding: master 1 with we=4'b0011, wdata=0xAABBCCDD -> dmem_we_o=4'b0011 and dmem_wdata_o=0xAABBCCDD. With no request, dmem_we_o=4'h0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Types and helpers for the data-memory arbiter.
package dmem_arb_pkg;
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int DMEM_ARB_MAX_MASTERS = 8;
    localparam int DMEM_ARB_MAX_IDX_W   = $clog2(DMEM_ARB_MAX_MASTERS);

    // OR-reduction of set-bit positions; exact for one-hot or all-zero input.
    function automatic logic [DMEM_ARB_MAX_IDX_W-1:0] onehot_to_idx(
        input logic [DMEM_ARB_MAX_MASTERS-1:0] oh
    );
        logic [DMEM_ARB_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DMEM_ARB_MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | DMEM_ARB_MAX_IDX_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/riscv_defines.sv
// Core-wide bus widths shared by the data-side blocks.
package riscv_defines;
    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;
endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational requester selection: rotate-from-pointer round-robin or
// plain lowest-index priority, chosen by RR_EN.
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter bit RR_EN = 1'b0,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic found;

    function automatic int scan_pos(input int k);
        return RR_EN ? ((int'(ptr) + k) % N) : k;
    endfunction

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[scan_pos(k)]) begin
                found              = 1'b1;
                grant[scan_pos(k)] = 1'b1;
            end
        end
        idx = IDX_W'(onehot_to_idx(DMEM_ARB_MAX_MASTERS'(grant)));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the core data-memory port between N_MASTERS requesters (0 = LSU).
// Define DMEM_ARB_RR_EN for round-robin; otherwise fixed lowest-index priority.
module dmem_arbiter
    import riscv_defines::*;
    import dmem_arb_pkg::*;
#(
    parameter int N_MASTERS = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [N_MASTERS-1:0]                        m_valid_i,
    input  logic [N_MASTERS-1:0][RISCV_ADDR_WIDTH-1:0]  m_addr_i,
    input  logic [N_MASTERS-1:0][RISCV_WORD_WIDTH-1:0]  m_wdata_i,
    input  logic [N_MASTERS-1:0][3:0]                   m_we_i,
    output logic [N_MASTERS-1:0]                        m_ready_o,
    output logic [RISCV_WORD_WIDTH-1:0]                 m_rdata_o,
    output logic                                        dmem_valid_o,
    input  logic                                        dmem_ready_i,
    output logic [RISCV_ADDR_WIDTH-1:0]                 dmem_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0]                 dmem_wdata_o,
    output logic [3:0]                                  dmem_we_o,
    input  logic [RISCV_WORD_WIDTH-1:0]                 dmem_rdata_i,
    output logic [N_MASTERS-1:0]                        grant_o,
    output logic                                        busy_o,
    output logic                                        protocol_err_o
);

    localparam int IDX_W = $clog2(N_MASTERS);
`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     winner;
    logic [N_MASTERS-1:0] winner_oh;
    logic                 win_valid;
    logic                 complete;

    rr_pick #(
        .N     (N_MASTERS),
        .RR_EN (RR_EN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (m_valid_i),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // rst_n gates the request path so nothing reaches memory while in reset.
    always_comb begin
        winner         = (state_q == ARB_BUSY) ? owner_q : pick_idx;
        win_valid      = rst_n & m_valid_i[winner];
        complete       = win_valid & dmem_ready_i;
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        protocol_err_o = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid && !dmem_ready_i) begin
                    state_d = ARB_BUSY;
                    owner_d = winner;
                end
            end
            ARB_BUSY: begin
                if (!m_valid_i[owner_q]) begin
                    state_d        = ARB_IDLE;
                    protocol_err_o = 1'b1;
                end else if (complete) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (complete) begin
            rr_ptr_d = (winner == IDX_W'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
    end

    assign winner_oh    = N_MASTERS'(1) << winner;
    assign dmem_valid_o = win_valid;
    assign dmem_addr_o  = m_addr_i[winner];
    assign dmem_wdata_o = m_wdata_i[winner];
    assign dmem_we_o    = win_valid ? m_we_i[winner] : 4'h0;
    assign grant_o      = win_valid ? winner_oh : '0;
    assign m_ready_o    = complete ? winner_oh : '0;
    assign m_rdata_o    = dmem_rdata_i;
    assign busy_o       = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a completion scoreboard.
module tb_dmem_arbiter;
    import riscv_defines::*;
    import dmem_arb_pkg::*;

    localparam int N = 2;

    logic                                   clk = 1'b0;
    logic                                   rst_n;
    logic [N-1:0]                           m_valid_i;
    logic [N-1:0][RISCV_ADDR_WIDTH-1:0]     m_addr_i;
    logic [N-1:0][RISCV_WORD_WIDTH-1:0]     m_wdata_i;
    logic [N-1:0][3:0]                      m_we_i;
    logic [N-1:0]                           m_ready_o;
    logic [RISCV_WORD_WIDTH-1:0]            m_rdata_o;
    logic                                   dmem_valid_o;
    logic                                   dmem_ready_i;
    logic [RISCV_ADDR_WIDTH-1:0]            dmem_addr_o;
    logic [RISCV_WORD_WIDTH-1:0]            dmem_wdata_o;
    logic [3:0]                             dmem_we_o;
    logic [RISCV_WORD_WIDTH-1:0]            dmem_rdata_i;
    logic [N-1:0]                           grant_o;
    logic                                   busy_o;
    logic                                   protocol_err_o;

    logic [RISCV_WORD_WIDTH-1:0] exp_q[$];
    logic [N-1:0]                exp_m_q[$];
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.N_MASTERS(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_valid_i      (m_valid_i),
        .m_addr_i       (m_addr_i),
        .m_wdata_i      (m_wdata_i),
        .m_we_i         (m_we_i),
        .m_ready_o      (m_ready_o),
        .m_rdata_o      (m_rdata_o),
        .dmem_valid_o   (dmem_valid_o),
        .dmem_ready_i   (dmem_ready_i),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_rdata_i   (dmem_rdata_i),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory model: read data is a fixed function of the presented address.
    assign dmem_rdata_i = mem_word(dmem_addr_o);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] m_oh, input logic [31:0] addr);
        exp_m_q.push_back(m_oh);
        exp_q.push_back(mem_word(addr));
    endtask

    task automatic settle();
        #1;
        if (m_ready_o !== '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 64'(m_ready_o), 64'd0);
            end else begin
                check("sb_master", 64'(m_ready_o), 64'(exp_m_q.pop_front()));
                check("sb_rdata", 64'(m_rdata_o), 64'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] g;
        rst_n        = 1'b0;
        m_valid_i    = 2'b11;
        m_addr_i     = '0;
        m_wdata_i    = '0;
        m_we_i       = {4'hF, 4'hF};
        dmem_ready_i = 1'b1;
        next();

        // Reset: everything quiet even with requests pending.
        settle();
        check("rst_valid", 64'(dmem_valid_o), 64'd0);
        check("rst_ready", 64'(m_ready_o), 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_perr", 64'(protocol_err_o), 64'd0);
        check("rst_we", 64'(dmem_we_o), 64'd0);
        rst_n     = 1'b1;
        m_valid_i = 2'b00;
        m_we_i    = '0;
        next();

        // Single-cycle read from master 0.
        m_valid_i   = 2'b01;
        m_addr_i[0] = 32'h100;
        push(2'b01, 32'h100);
        settle();
        check("t1_valid", 64'(dmem_valid_o), 64'd1);
        check("t1_addr", 64'(dmem_addr_o), 64'h100);
        check("t1_grant", 64'(grant_o), 64'b01);
        check("t1_busy", 64'(busy_o), 64'd0);
        next();
        m_valid_i = 2'b00;
        settle();
        check("t1_busy_after", 64'(busy_o), 64'd0);
        next();

        // Locked grant: master 1 owns the port while master 0 waits.
        m_valid_i    = 2'b10;
        m_addr_i[1]  = 32'h200;
        dmem_ready_i = 1'b0;
        push(2'b10, 32'h200);
        settle();
        check("lk_t0_addr", 64'(dmem_addr_o), 64'h200);
        check("lk_t0_grant", 64'(grant_o), 64'b10);
        next();
        m_valid_i   = 2'b11;
        m_addr_i[0] = 32'h104;
        push(2'b01, 32'h104);
        settle();
        check("lk_t1_busy", 64'(busy_o), 64'd1);
        check("lk_t1_addr", 64'(dmem_addr_o), 64'h200);
        check("lk_t1_ready", 64'(m_ready_o), 64'd0);
        next();
        settle();
        check("lk_t2_addr", 64'(dmem_addr_o), 64'h200);
        next();
        dmem_ready_i = 1'b1;
        settle();
        check("lk_t3_addr", 64'(dmem_addr_o), 64'h200);
        check("lk_t3_ready", 64'(m_ready_o), 64'b10);
        next();
        m_valid_i = 2'b01;
        settle();
        check("lk_t4_grant", 64'(grant_o), 64'b01);
        check("lk_t4_addr", 64'(dmem_addr_o), 64'h104);
        next();
        m_valid_i = 2'b00;

        // Write forwarding from master 1.
        m_valid_i    = 2'b10;
        m_addr_i[1]  = 32'h300;
        m_we_i[1]    = 4'b0011;
        m_wdata_i[1] = 32'hAABBCCDD;
        push(2'b10, 32'h300);
        settle();
        check("wr_we", 64'(dmem_we_o), 64'b0011);
        check("wr_wdata", 64'(dmem_wdata_o), 64'hAABBCCDD);
        next();
        m_valid_i = 2'b00;
        settle();
        check("idle_we", 64'(dmem_we_o), 64'd0);
        check("idle_valid", 64'(dmem_valid_o), 64'd0);
        check("idle_grant", 64'(grant_o), 64'd0);
        next();
        m_we_i = '0;

        // Continuous contention with single-cycle memory.
        m_valid_i   = 2'b11;
        m_addr_i[0] = 32'h110;
        m_addr_i[1] = 32'h210;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            g = 2'b01;
`endif
            push(g, (g == 2'b01) ? 32'h110 : 32'h210);
            settle();
            check($sformatf("arb_grant_%0d", i), 64'(grant_o), 64'(g));
            next();
        end
        m_valid_i = 2'b00;
        next();

        // Protocol violation: owner drops valid while locked.
        m_valid_i    = 2'b01;
        m_addr_i[0]  = 32'h120;
        dmem_ready_i = 1'b0;
        settle();
        check("pv_valid", 64'(dmem_valid_o), 64'd1);
        next();
        m_valid_i = 2'b00;
        settle();
        check("pv_perr", 64'(protocol_err_o), 64'd1);
        check("pv_valid_drop", 64'(dmem_valid_o), 64'd0);
        next();
        settle();
        check("pv_perr_clear", 64'(protocol_err_o), 64'd0);
        check("pv_busy", 64'(busy_o), 64'd0);
        next();

        // Reset asserted while master 1 holds the lock.
        m_valid_i   = 2'b10;
        m_addr_i[1] = 32'h220;
        m_we_i[1]   = 4'hF;
        settle();
        next();
        settle();
        check("rm_busy_pre", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        settle();
        check("rm_busy", 64'(busy_o), 64'd0);
        check("rm_valid", 64'(dmem_valid_o), 64'd0);
        check("rm_grant", 64'(grant_o), 64'd0);
        check("rm_we", 64'(dmem_we_o), 64'd0);
        next();
        rst_n        = 1'b1;
        dmem_ready_i = 1'b1;
        m_we_i[1]    = 4'h0;
        push(2'b10, 32'h220);
        settle();
        check("rm_regrant", 64'(grant_o), 64'b10);
        check("rm_revalid", 64'(dmem_valid_o), 64'd1);
        next();
        m_valid_i = 2'b00;
        settle();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
